led_pattern_engine: RTL and testbench

//  Parametrised LED pattern generator for the DE2-115 LEDR bank. Drives N_LEDS

---
 rtl/led_pattern_engine.sv | 173 +++++++++++++++++
 tb/tb_led_pattern_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// LED pattern engine for the DE2-115 LEDR bank.
// Rotate, bounce, bar fill/drain and inverted-rotate patterns with a
// rate divider, pause and single-step. All controls are synchronised.
module led_pattern_engine #(
    parameter int unsigned N_LEDS  = 18,
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned BASE_HZ = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              pause,
    input  logic              step,
    input  logic [1:0]        mode,
    input  logic              dir,
    input  logic [1:0]        speed,
    output logic [N_LEDS-1:0] LEDR,
    output logic              tick
);

    localparam int unsigned DIV_W = $clog2(CLK_HZ / BASE_HZ);

    // Terminal counts: speed s advances at BASE_HZ << s
    localparam logic [DIV_W-1:0] DIV_MAX_0 = DIV_W'(CLK_HZ / (BASE_HZ << 0) - 1);
    localparam logic [DIV_W-1:0] DIV_MAX_1 = DIV_W'(CLK_HZ / (BASE_HZ << 1) - 1);
    localparam logic [DIV_W-1:0] DIV_MAX_2 = DIV_W'(CLK_HZ / (BASE_HZ << 2) - 1);
    localparam logic [DIV_W-1:0] DIV_MAX_3 = DIV_W'(CLK_HZ / (BASE_HZ << 3) - 1);

    localparam logic [1:0] MODE_ROTATE = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_BAR    = 2'b10;
    localparam logic [1:0] MODE_INVERT = 2'b11;

    localparam logic [N_LEDS-1:0] LED_ONE  = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] LED_ALL  = {N_LEDS{1'b1}};
    localparam logic [N_LEDS-1:0] LED_NONE = '0;

    // Synchroniser stages; step has a third stage for edge detection
    logic       pause_s1, pause_s2;
    logic       step_s1, step_s2, step_s3;
    logic [1:0] mode_s1, mode_s2;
    logic       dir_s1, dir_s2;
    logic [1:0] speed_s1, speed_s2;

    logic [1:0]        mode_q;
    logic [DIV_W-1:0]  div_q, div_d, div_max;
    logic [N_LEDS-1:0] led_q, led_d, led_adv;
    logic              bounce_up_q, bounce_up_d, up_adv;
    logic              bar_fill_q, bar_fill_d, fill_adv;
    logic              tick_q, tick_d;
    logic              reload, step_rise, advance;

    // Two-flop synchronisers for all board controls
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pause_s1 <= 1'b0;  pause_s2 <= 1'b0;
            step_s1  <= 1'b0;  step_s2  <= 1'b0;  step_s3 <= 1'b0;
            mode_s1  <= 2'b00; mode_s2  <= 2'b00;
            dir_s1   <= 1'b0;  dir_s2   <= 1'b0;
            speed_s1 <= 2'b00; speed_s2 <= 2'b00;
        end else begin
            pause_s1 <= pause;  pause_s2 <= pause_s1;
            step_s1  <= step;   step_s2  <= step_s1;  step_s3 <= step_s2;
            mode_s1  <= mode;   mode_s2  <= mode_s1;
            dir_s1   <= dir;    dir_s2   <= dir_s1;
            speed_s1 <= speed;  speed_s2 <= speed_s1;
        end
    end

    // Divider terminal count for the selected rate
    always_comb begin
        case (speed_s2)
            2'd0:    div_max = DIV_MAX_0;
            2'd1:    div_max = DIV_MAX_1;
            2'd2:    div_max = DIV_MAX_2;
            default: div_max = DIV_MAX_3;
        endcase
    end

    // Pattern value and phase flags one advance ahead of the current state
    always_comb begin
        led_adv  = led_q;
        up_adv   = bounce_up_q;
        fill_adv = bar_fill_q;
        case (mode_q)
            MODE_BOUNCE: begin
                // Reverse on the endpoint itself so endpoints are shown once
                if (bounce_up_q) begin
                    if (led_q[N_LEDS-1]) begin
                        led_adv = led_q >> 1;
                        up_adv  = 1'b0;
                    end else begin
                        led_adv = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        led_adv = led_q << 1;
                        up_adv  = 1'b1;
                    end else begin
                        led_adv = led_q >> 1;
                    end
                end
            end
            MODE_BAR: begin
                // Phase flips when the bar is full (drain) or empty (fill)
                fill_adv = bar_fill_q ? (led_q != LED_ALL) : (led_q == LED_NONE);
                led_adv  = dir_s2 ? {fill_adv, led_q[N_LEDS-1:1]}
                                  : {led_q[N_LEDS-2:0], fill_adv};
            end
            default: begin
                led_adv = dir_s2 ? {led_q[0], led_q[N_LEDS-1:1]}
                                 : {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
            end
        endcase
    end

    // Next state: mode reload beats timed or stepped advance
    always_comb begin
        reload    = (mode_s2 != mode_q);
        step_rise = step_s2 & ~step_s3;
        advance   = 1'b0;
        div_d       = div_q;
        led_d       = led_q;
        bounce_up_d = bounce_up_q;
        bar_fill_d  = bar_fill_q;
        if (reload) begin
            div_d       = '0;
            bounce_up_d = 1'b1;
            bar_fill_d  = 1'b1;
            case (mode_s2)
                MODE_ROTATE: led_d = LED_ONE;
                MODE_BOUNCE: led_d = LED_ONE;
                MODE_BAR:    led_d = LED_NONE;
                default:     led_d = ~LED_ONE;
            endcase
        end else if (pause_s2) begin
            advance = step_rise;
        end else if (div_q >= div_max) begin
            div_d   = '0;
            advance = 1'b1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        if (advance) begin
            led_d       = led_adv;
            bounce_up_d = up_adv;
            bar_fill_d  = fill_adv;
        end
        tick_d = advance;
    end

    // Pattern, divider and tick registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mode_q      <= MODE_ROTATE;
            div_q       <= '0;
            led_q       <= LED_ONE;
            bounce_up_q <= 1'b1;
            bar_fill_q  <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            mode_q      <= mode_s2;
            div_q       <= div_d;
            led_q       <= led_d;
            bounce_up_q <= bounce_up_d;
            bar_fill_q  <= bar_fill_d;
            tick_q      <= tick_d;
        end
    end

    assign LEDR = led_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (N_LEDS=8, CLK_HZ=16, BASE_HZ=1).
// Directed scenarios followed by randomized control activity, each cycle
// compared against a position/phase based reference model.
module tb_led_pattern_engine;

    localparam int N       = 8;
    localparam int CLK_HZ  = 16;
    localparam int BASE_HZ = 1;
    localparam int MASK    = (1 << N) - 1;

    logic         CLOCK_50 = 1'b0;
    logic         reset    = 1'b1;
    logic         pause    = 1'b0;
    logic         step     = 1'b0;
    logic [1:0]   mode     = 2'b00;
    logic         dir      = 1'b0;
    logic [1:0]   speed    = 2'b00;
    logic [N-1:0] LEDR;
    logic         tick;

    always #5 CLOCK_50 = ~CLOCK_50;

    led_pattern_engine #(
        .N_LEDS  (N),
        .CLK_HZ  (CLK_HZ),
        .BASE_HZ (BASE_HZ)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .pause    (pause),
        .step     (step),
        .mode     (mode),
        .dir      (dir),
        .speed    (speed),
        .LEDR     (LEDR),
        .tick     (tick)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: pattern kept as position / phase / bar value
    logic [6:0] in_hist[$];
    int m_mode, m_div, m_pos, m_phase, m_bar, m_fill, m_tick;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    function automatic int period_of(input int s);
        return CLK_HZ / (BASE_HZ << s);
    endfunction

    function automatic int model_led();
        case (m_mode)
            0:       return 1 << m_pos;
            3:       return MASK & ~(1 << m_pos);
            1:       return 1 << ((m_phase < N) ? m_phase : 2 * N - 2 - m_phase);
            default: return m_bar;
        endcase
    endfunction

    task automatic model_seed(input int md);
        m_mode  = md;
        m_pos   = 0;
        m_phase = 0;
        m_bar   = 0;
        m_fill  = 1;
    endtask

    task automatic model_reset();
        model_seed(0);
        m_div  = 0;
        m_tick = 0;
        in_hist.delete();
        repeat (4) in_hist.push_front(7'd0);
    endtask

    task automatic model_advance(input bit d);
        case (m_mode)
            1: m_phase = (m_phase + 1) % (2 * N - 2);
            2: begin
                if (m_fill == 1 && m_bar == MASK) m_fill = 0;
                else if (m_fill == 0 && m_bar == 0) m_fill = 1;
                m_bar = d ? ((m_bar >> 1) | (m_fill << (N - 1)))
                          : (((m_bar << 1) | m_fill) & MASK);
            end
            default: m_pos = d ? (m_pos + N - 1) % N : (m_pos + 1) % N;
        endcase
        m_tick = 1;
    endtask

    // Controls seen by the logic at an edge are those present two edges earlier
    task automatic model_edge();
        logic [6:0] vis, prev;
        in_hist.push_front({step, pause, mode, dir, speed});
        vis  = in_hist[2];
        prev = in_hist[3];
        void'(in_hist.pop_back());
        m_tick = 0;
        if (int'(vis[4:3]) != m_mode) begin
            model_seed(int'(vis[4:3]));
            m_div = 0;
        end else if (vis[5]) begin
            if (vis[6] && !prev[6]) model_advance(vis[2]);
        end else if (m_div >= period_of(int'(vis[1:0])) - 1) begin
            m_div = 0;
            model_advance(vis[2]);
        end else begin
            m_div++;
        end
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        model_edge();
        #1;
        check_eq("ledr", 32'(LEDR), 32'(model_led()));
        check_eq("tick", 32'(tick), 32'(m_tick));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        check_eq("rst_ledr", 32'(LEDR), 32'h1);
        check_eq("rst_tick", 32'(tick), 32'h0);
        model_reset();
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        // 1: rotate left at slowest rate, then async reset mid-pattern
        do_reset();
        run(140);
        run(37);
        do_reset();
        run(20);

        // 2: rotate right fast; speed change with divider part-way through
        dir = 1'b1; speed = 2'd3;
        run(20);
        speed = 2'd0;
        for (int i = 0; i < 40 && m_div != 10; i++) cycle();
        speed = 2'd3;
        run(20);

        // 3: bounce
        mode = 2'd1; speed = 2'd3;
        run(60);

        // 4: bar fill/drain both directions, reloaded via rotate
        dir = 1'b0; mode = 2'd0; run(5);
        mode = 2'd2; run(40);
        dir = 1'b1; mode = 2'd0; run(5);
        mode = 2'd2; run(40);

        // 5: pause, held step, unpaused step
        mode = 2'd0; dir = 1'b0; speed = 2'd1;
        run(10);
        pause = 1'b1; run(100);
        step = 1'b1;  run(50);
        step = 1'b0;  run(10);
        pause = 1'b0; step = 1'b1; run(20);
        step = 1'b0;  run(5);

        // 6: bounce -> inverted rotate at LEDR=10, running then paused
        mode = 2'd1; speed = 2'd3; run(5);
        for (int i = 0; i < 40 && model_led() != 'h10; i++) cycle();
        mode = 2'd3; run(20);
        pause = 1'b1; mode = 2'd1; run(5);
        for (int i = 0; i < 20 && model_led() != 'h10; i++) begin
            step = 1'b1; run(3);
            step = 1'b0; run(3);
        end
        mode = 2'd3; run(10);
        pause = 1'b0;

        // Randomized control activity
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) dir = ~dir;
            if ($urandom_range(31) == 0) speed = 2'($urandom_range(3));
            if ($urandom_range(39) == 0) pause = ~pause;
            if ($urandom_range(7) == 0) step = ~step;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
